// File: rtl/thre_pkg.sv
// rtl/thre_pkg.sv - shared state encoding and byte-geometry helpers for the threshold loader
package thre_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int BYTE_W = 8;

   function automatic int bytes_per_word(input int data_width);
      return data_width / BYTE_W;
   endfunction

endpackage

// File: rtl/thre_word_assembler.sv
// rtl/thre_word_assembler.sv - MSB-first byte-to-word assembler with completion pulse
module thre_word_assembler
   import thre_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear_i,
   input  logic                  byte_valid_i,
   input  logic [BYTE_W-1:0]     byte_i,
   output logic [DATA_WIDTH-1:0] word_o,
   output logic                  word_valid_o
);

   localparam int BPW = bytes_per_word(DATA_WIDTH);
   localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          last;

   // word_o already includes the byte being accepted, so the word can be stored on the same edge
   if (DATA_WIDTH > BYTE_W) begin : g_shift
      logic [DATA_WIDTH-BYTE_W-1:0] shift_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst)               shift_q <= '0;
         else if (byte_valid_i) shift_q <= word_o[DATA_WIDTH-BYTE_W-1:0];
      end
      assign word_o = {shift_q, byte_i};
   end else begin : g_byte
      assign word_o = byte_i;
   end

   assign last         = (cnt_q == CW'(BPW - 1));
   assign word_valid_o = byte_valid_i && last && !clear_i;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)           cnt_d = '0;
      else if (byte_valid_i) cnt_d = last ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/thre_buffer_loader.sv
// rtl/thre_buffer_loader.sv - byte-streamed threshold RAM loader with registered read port
// Optional checksum word after the data words: THRE_LOAD_CSUM_EN
module thre_buffer_loader
   import thre_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int DATA_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [BYTE_W-1:0]     s_data,
   output logic                  busy,
   output logic                  done,
   output logic                  load_err,
   input  logic                  enable,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data_o
);

   localparam int AIW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

   state_t                state_q, state_d;
   logic [AIW-1:0]        word_cnt_q, word_cnt_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] ram_q [0:(1<<AIW)-1];
   logic                  ram_we;
   logic                  accept;
   logic                  start_ok;
   logic [DATA_WIDTH-1:0] word;
   logic                  word_valid;
   logic                  in_range;

`ifdef THRE_LOAD_CSUM_EN
   logic [DATA_WIDTH-1:0] csum_q, csum_d;
   logic                  load_err_q, load_err_d;
   assign load_err = load_err_q;
`else
   assign load_err = 1'b0;
`endif

   assign s_ready  = (state_q == ST_LOAD) || (state_q == ST_CHECK);
   assign accept   = s_valid && s_ready;
   assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign busy     = busy_q;
   assign done     = done_q;
   assign data_o   = data_q;
   assign in_range = {1'b0, addr} < (ADDR_WIDTH+1)'(DATA_DEPTH);

   thre_word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (start_ok),
      .byte_valid_i (accept),
      .byte_i       (s_data),
      .word_o       (word),
      .word_valid_o (word_valid)
   );

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      busy_d     = busy_q;
      done_d     = done_q;
      ram_we     = 1'b0;
`ifdef THRE_LOAD_CSUM_EN
      csum_d     = csum_q;
      load_err_d = load_err_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_LOAD;
               word_cnt_d = '0;
               busy_d     = 1'b1;
               done_d     = 1'b0;
`ifdef THRE_LOAD_CSUM_EN
               csum_d     = '0;
               load_err_d = 1'b0;
`endif
            end
         end
         ST_LOAD: begin
            if (word_valid) begin
               ram_we     = 1'b1;
               word_cnt_d = word_cnt_q + AIW'(1);
`ifdef THRE_LOAD_CSUM_EN
               csum_d     = csum_q ^ word;
               if (word_cnt_q == AIW'(DATA_DEPTH - 1)) state_d = ST_CHECK;
`else
               if (word_cnt_q == AIW'(DATA_DEPTH - 1)) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
`endif
            end
         end
`ifdef THRE_LOAD_CSUM_EN
         ST_CHECK: begin
            if (word_valid) begin
               state_d    = ST_DONE;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               load_err_d = (word != csum_q);
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         word_cnt_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef THRE_LOAD_CSUM_EN
         csum_q     <= '0;
         load_err_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef THRE_LOAD_CSUM_EN
         csum_q     <= csum_d;
         load_err_q <= load_err_d;
`endif
      end
   end

   // RAM keeps its contents across reset so a partial load is not lost
   always_ff @(posedge clk) begin
      if (ram_we) ram_q[word_cnt_q] <= word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         data_q <= '0;
      else if (enable) data_q <= in_range ? ram_q[addr[AIW-1:0]] : '0;
   end

endmodule

// File: tb/tb_thre_buffer_loader.sv
// tb/tb_thre_buffer_loader.sv - randomized self-checking bench against a byte-count reference model
module tb_thre_buffer_loader;

   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int DEPTH = 2;
`ifdef THRE_LOAD_CSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif
   localparam int NB = 4 * (DEPTH + (CSUM ? 1 : 0));

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          s_valid = 1'b0;
   logic [7:0]    s_data = '0;
   logic          enable = 1'b0;
   logic [AW-1:0] addr = '0;
   logic          s_ready, busy, done, load_err;
   logic [DW-1:0] data_o;

   int n_vec  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;
   int acc_cnt = 0;

   always #5 clk = ~clk;

   thre_buffer_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .busy(busy), .done(done), .load_err(load_err),
      .enable(enable), .addr(addr), .data_o(data_o)
   );

   // reference model: a load is "NB bytes after start"; every 4th byte completes a word
   bit          m_loading, m_busy, m_done, m_err;
   int          m_bytes, m_w;
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_word, m_csum, m_data, m_rd;

   initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_loading = 0; m_busy = 0; m_done = 0; m_err = 0; m_bytes = 0; m_data = '0;
      end else begin
         m_rd = m_data;
         if (enable) m_rd = (addr < DEPTH) ? m_mem[addr] : 32'h0;
         if (start && !m_loading) begin
            m_loading = 1; m_busy = 1; m_done = 0; m_err = 0; m_bytes = 0; m_csum = '0;
         end else if (m_loading && s_valid) begin
            m_word = {m_word[23:0], s_data};
            m_bytes++;
            if (m_bytes % 4 == 0) begin
               m_w = m_bytes / 4 - 1;
               if (m_w < DEPTH) begin
                  m_mem[m_w] = m_word;
                  m_csum ^= m_word;
               end else begin
                  m_err = (m_word != m_csum);
               end
               if (m_bytes == NB) begin
                  m_loading = 0; m_busy = 0; m_done = 1;
               end
            end
         end
         m_data = m_rd;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("s_ready", 32'(s_ready), 32'(m_loading));
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         chk("load_err", 32'(load_err), 32'(m_err));
         chk("data_o", data_o, m_data);
      end
   end

   // called at negedge+1: drives inputs for the coming posedge, returns at the next negedge+1
   task automatic step(input bit st, input bit v, input logic [7:0] d, input bit en,
                       input logic [AW-1:0] a, output bit took);
      start = st; s_valid = v; s_data = d; enable = en; addr = a;
      took = s_ready && v;
      if (took) acc_cnt++;
      @(negedge clk); #1;
   endtask

   task automatic load_seq(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] ck,
                           input bit gaps, input int rd_idx);
      logic [7:0] bq[$];
      logic [31:0] ws [3];
      bit took;
      int i, guard;
      ws[0] = w0; ws[1] = w1; ws[2] = ck;
      for (int w = 0; w < NB / 4; w++)
         for (int b = 3; b >= 0; b--) bq.push_back(ws[w][b*8 +: 8]);
      step(1, 0, 8'h00, 0, '0, took);
      chk("busy_after_start", 32'(busy), 32'd1);
      i = 0; guard = 0;
      while (i < NB && guard < 100) begin
         step(0, gaps ? (guard % 2 == 0) : 1'b1, bq[i], i == rd_idx, '0, took);
         if (took) begin
            if (i == rd_idx) chk("collision_old", data_o, 32'h12345678);
            i++;
            chk("done_vs_count", 32'(done), 32'(i == NB));
         end
         guard++;
      end
      chk("load_bytes", i, NB);
      step(0, 0, 8'h00, 0, '0, took);
   endtask

   bit t;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      rst = 0; chk_en = 1;
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_data", data_o, 0);

      // basic load, then reads and hold
      load_seq(32'h12345678, 32'h9ABCDEF0, 32'h88888888, 0, -1);
      chk("basic_done", 32'(done), 1);
      step(0, 0, 0, 1, 8'd0, t); chk("rd0", data_o, 32'h12345678);
      step(0, 0, 0, 1, 8'd1, t); chk("rd1", data_o, 32'h9ABCDEF0);
      step(0, 0, 0, 0, 8'd0, t); chk("rd_hold", data_o, 32'h9ABCDEF0);
      step(0, 0, 0, 1, 8'd5, t); chk("rd_oor", data_o, 32'h0);

      // valid gaps and excess bytes
      acc_cnt = 0;
      load_seq(32'h12345678, 32'h9ABCDEF0, 32'h88888888, 1, -1);
      repeat (3) step(0, 1, 8'hEE, 0, '0, t);
      chk("gap_accepts", acc_cnt, NB);
      step(0, 0, 0, 1, 8'd0, t); chk("gap_rd0", data_o, 32'h12345678);
      step(0, 0, 0, 1, 8'd1, t); chk("gap_rd1", data_o, 32'h9ABCDEF0);

      // read-first collision on word 0
      load_seq(32'hAABBCCDD, 32'h11223344, 32'hAABBCCDD ^ 32'h11223344, 0, 3);
      step(0, 0, 0, 1, 8'd0, t); chk("collision_new", data_o, 32'hAABBCCDD);

      // reset after 5 bytes
      step(1, 0, 0, 0, '0, t);
      begin
         logic [7:0] rb [5];
         rb = '{8'h0B, 8'hAD, 8'hF0, 8'h0D, 8'h55};
         for (int i = 0; i < 5; i++) step(0, 1, rb[i], 0, '0, t);
      end
      rst = 1; #1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_ready", 32'(s_ready), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_data", data_o, 0);
      @(negedge clk); #1; rst = 0;
      step(0, 0, 0, 1, 8'd0, t); chk("midrst_ram0", data_o, 32'h0BADF00D);
      load_seq(32'h01020304, 32'h05060708, 32'h01020304 ^ 32'h05060708, 0, -1);
      chk("after_rst_done", 32'(done), 1);

      // start pulse mid-load is ignored
      begin
         logic [7:0] sb [12];
         logic [31:0] cw;
         cw = 32'hCAFEBABE ^ 32'hDEADBEEF;
         sb = '{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                cw[31:24], cw[23:16], cw[15:8], cw[7:0]};
         step(1, 0, 0, 0, '0, t);
         for (int i = 0; i < 3; i++) step(0, 1, sb[i], 0, '0, t);
         step(1, 0, 0, 0, '0, t);
         for (int i = 3; i < NB; i++) begin
            chk("ign_not_done", 32'(done), 0);
            step(0, 1, sb[i], 0, '0, t);
         end
         chk("ign_done", 32'(done), 1);
         step(0, 0, 0, 1, 8'd0, t); chk("ign_rd0", data_o, 32'hCAFEBABE);
      end

`ifdef THRE_LOAD_CSUM_EN
      load_seq(32'h12345678, 32'h9ABCDEF0, 32'h88888888, 0, -1);
      chk("csum_ok_done", 32'(done), 1);
      chk("csum_ok_err", 32'(load_err), 0);
      load_seq(32'h12345678, 32'h9ABCDEF0, 32'h00000000, 0, -1);
      chk("csum_bad_done", 32'(done), 1);
      chk("csum_bad_err", 32'(load_err), 1);
`endif

      // random traffic with occasional starts and resets
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst = 1;
            @(negedge clk); #1;
            rst = 0;
         end else begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, 8'($urandom),
                 $urandom_range(0, 1) == 1, AW'($urandom_range(0, 3)), t);
         end
      end

      step(0, 0, 0, 0, '0, t);
      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
